// File: rtl/taylor_exp_seq_pkg.sv
// Shared constants and FSM state encoding for the Taylor-series e^x sequencer.
package taylor_exp_seq_pkg;

  localparam int unsigned TAYLOR_WIDTH   = 16;
  localparam int unsigned TAYLOR_FRAC    = 11;
  localparam int unsigned TAYLOR_N_TERMS = 8;

  localparam logic [15:0] TAYLOR_ONE_Q   = 16'h0800;
  localparam logic [15:0] TAYLOR_SAT_MAX = 16'h7FFF;
  localparam logic [15:0] TAYLOR_SAT_MIN = 16'h8000;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StMul,
    StDiv,
    StWb,
    StDone
  } state_e;

endpackage

// File: rtl/taylor_exp_seq_divider.sv
// Unsigned restoring divider, WIDTH cycles per quotient; the first step is taken on the go edge.
module taylor_exp_seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             custom_reset,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             ready
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [WIDTH-1:0] rem_in, quo_in, rem_nx, quo_nx;
  logic [WIDTH:0]   rem_sh, rem_diff;

  always_comb begin
    rem_in   = go ? '0 : rem_q;
    quo_in   = go ? dividend : quo_q;
    rem_sh   = {rem_in, quo_in[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, divisor};
    // Borrow out of the trial subtraction means the divisor did not fit.
    quo_nx   = {quo_in[WIDTH-2:0], ~rem_diff[WIDTH]};
    rem_nx   = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (custom_reset) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (go) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= CW'(WIDTH - 1);
      run_q <= 1'b1;
    end else if (cnt_q != '0) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign quotient = quo_q;
  assign ready    = run_q && (cnt_q == '0);

endmodule

// File: rtl/taylor_exp_seq.sv
// Sequencer computing e^x in signed Q5.11 by Taylor series, driving an external term register.
// Optional macro TAYLOR_EARLY_EXIT_EN: finish as soon as a zero term is produced.
module taylor_exp_seq
  import taylor_exp_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = TAYLOR_WIDTH,
  parameter int unsigned FRAC    = TAYLOR_FRAC,
  parameter int unsigned N_TERMS = TAYLOR_N_TERMS
) (
  input  logic             clk,
  input  logic             custom_reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             term_init,
  output logic             term_load,
  output logic [WIDTH-1:0] term_d,
  input  logic [WIDTH-1:0] term_q
);

  localparam int unsigned NW = 5;
  localparam logic [NW-1:0] LastN = NW'(N_TERMS - 1);
  localparam logic [WIDTH-1:0] OneQ = WIDTH'(1 << FRAC);
  localparam logic signed [2*WIDTH-1:0] SatMax = (2*WIDTH)'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [2*WIDTH-1:0] SatMin = ~SatMax;

  state_e           state_q;
  logic [WIDTH-1:0] x_q, sum_q, result_q, term_d_q;
  logic [NW-1:0]    n_q;
  logic             neg_q, busy_q, done_q, ovf_q, init_q, load_q;

  logic signed [2*WIDTH-1:0] tq_ext, xq_ext, prod, prod_sh;
  logic [WIDTH-1:0]          p_sat, p_mag, div_quo, q_signed, sum_sat;
  logic                      p_clip, sum_clip, div_ready, last_iter;
  logic signed [WIDTH:0]     sum_ext;

  always_comb begin
    tq_ext  = {{WIDTH{term_q[WIDTH-1]}}, term_q};
    xq_ext  = {{WIDTH{x_q[WIDTH-1]}}, x_q};
    prod    = tq_ext * xq_ext;
    prod_sh = prod >>> FRAC;
    p_clip  = 1'b0;
    p_sat   = prod_sh[WIDTH-1:0];
    if (prod_sh > SatMax) begin
      p_sat  = SatMax[WIDTH-1:0];
      p_clip = 1'b1;
    end else if (prod_sh < SatMin) begin
      p_sat  = SatMin[WIDTH-1:0];
      p_clip = 1'b1;
    end
    // -(-32768) wraps to 16'h8000, which is the correct unsigned magnitude.
    p_mag = p_sat[WIDTH-1] ? -p_sat : p_sat;
  end

  taylor_exp_seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk         (clk),
    .custom_reset(custom_reset),
    .go          (state_q == StMul),
    .dividend    (p_mag),
    .divisor     (WIDTH'(n_q)),
    .quotient    (div_quo),
    .ready       (div_ready)
  );

  always_comb begin
    q_signed = neg_q ? -div_quo : div_quo;
    sum_ext  = $signed({sum_q[WIDTH-1], sum_q}) + $signed({q_signed[WIDTH-1], q_signed});
    sum_clip = sum_ext[WIDTH] != sum_ext[WIDTH-1];
    sum_sat  = sum_ext[WIDTH-1:0];
    if (sum_clip) begin
      sum_sat = sum_ext[WIDTH] ? SatMin[WIDTH-1:0] : SatMax[WIDTH-1:0];
    end
`ifdef TAYLOR_EARLY_EXIT_EN
    last_iter = (n_q == LastN) || (term_d_q == '0);
`else
    last_iter = (n_q == LastN);
`endif
  end

  always_ff @(posedge clk) begin
    if (custom_reset) begin
      state_q  <= StIdle;
      x_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      term_d_q <= '0;
      n_q      <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      init_q   <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            x_q     <= x_in;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            init_q  <= 1'b1;
            state_q <= StInit;
          end
        end
        StInit: begin
          init_q  <= 1'b0;
          sum_q   <= OneQ;
          n_q     <= NW'(1);
          state_q <= StMul;
        end
        StMul: begin
          neg_q <= p_sat[WIDTH-1];
          if (p_clip) ovf_q <= 1'b1;
          state_q <= StDiv;
        end
        StDiv: begin
          if (div_ready) begin
            load_q   <= 1'b1;
            term_d_q <= q_signed;
            sum_q    <= sum_sat;
            if (sum_clip) ovf_q <= 1'b1;
            state_q  <= StWb;
          end
        end
        StWb: begin
          load_q <= 1'b0;
          if (last_iter) begin
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            result_q <= sum_q;
            state_q  <= StDone;
          end else begin
            n_q     <= n_q + NW'(1);
            state_q <= StMul;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign term_init = init_q;
  assign term_load = load_q;
  assign term_d    = term_d_q;

endmodule

// File: tb/tb_taylor_exp_seq.sv
// Self-checking bench for taylor_exp_seq against an integer Taylor-series model.
module tb_taylor_exp_seq;

  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        custom_reset, start;
  logic [15:0] x_in;
  logic        busy, done, overflow, term_init, term_load;
  logic [15:0] result, term_d, term_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  taylor_exp_seq dut (
    .clk         (clk),
    .custom_reset(custom_reset),
    .start       (start),
    .x_in        (x_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .term_init   (term_init),
    .term_load   (term_load),
    .term_d      (term_d),
    .term_q      (term_reg)
  );

  // External term register the sequencer drives.
  always @(posedge clk) begin
    if (custom_reset)   term_reg <= 16'h0000;
    else if (term_init) term_reg <= 16'h0800;
    else if (term_load) term_reg <= term_d;
  end

  int          m_terms[$];
  logic [15:0] m_res;
  bit          m_ovf;
  int          m_iters;

  task automatic model(input logic [15:0] x);
    int t, s, xv, p, q;
    m_terms.delete();
    m_ovf   = 0;
    m_iters = 0;
    t  = 2048;
    s  = 2048;
    xv = int'($signed(x));
    for (int n = 1; n < NT; n++) begin
      p = (t * xv) >>> 11;
      if (p > 32767) begin p = 32767; m_ovf = 1; end
      else if (p < -32768) begin p = -32768; m_ovf = 1; end
      q = p / n;
      s = s + q;
      if (s > 32767) begin s = 32767; m_ovf = 1; end
      else if (s < -32768) begin s = -32768; m_ovf = 1; end
      t = q;
      m_terms.push_back(q);
      m_iters = n;
`ifdef TAYLOR_EARLY_EXIT_EN
      if (q == 0) break;
`endif
    end
    m_res = 16'(s);
  endtask

  int          obs_first_ovf;
  logic [15:0] obs_terms[$];
  bit          both_hi = 0;

  task automatic run_one(input logic [15:0] x, input int exp_res, input string name);
    int c;
    bit seen, init1, busy1;
    model(x);
    @(negedge clk);
    x_in  = x;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x_in = 16'($urandom);
    obs_terms.delete();
    seen = 0; c = 0; obs_first_ovf = 0; init1 = 0; busy1 = 0;
    while (!seen && c < 400) begin
      @(negedge clk);
      c++;
      if (c == 1) begin init1 = term_init; busy1 = busy; end
      if (term_load) obs_terms.push_back(term_d);
      if (term_init && term_load) both_hi = 1;
      if (overflow && obs_first_ovf == 0) obs_first_ovf = c;
      if (done) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s done_timeout got=no_done want=done", name);
    end else begin
      total++;
      if (c !== 2 + 18 * m_iters) begin
        bad++; $display("FAIL %s latency got=%0d want=%0d", name, c, 2 + 18 * m_iters);
      end
      total++;
      if (result !== m_res) begin
        bad++; $display("FAIL %s result got=%h want=%h", name, result, m_res);
      end
      if (exp_res >= 0) begin
        total++;
        if (result !== 16'(exp_res)) begin
          bad++; $display("FAIL %s result_const got=%h want=%h", name, result, 16'(exp_res));
        end
      end
      total++;
      if (overflow !== m_ovf) begin
        bad++; $display("FAIL %s overflow got=%b want=%b", name, overflow, m_ovf);
      end
      total++;
      if ({init1, busy1, busy} !== 3'b110) begin
        bad++; $display("FAIL %s init_busy got=%b want=110", name, {init1, busy1, busy});
      end
      total++;
      if (obs_terms.size() !== m_terms.size()) begin
        bad++;
        $display("FAIL %s term_count got=%0d want=%0d", name, obs_terms.size(), m_terms.size());
      end else begin
        for (int i = 0; i < m_terms.size(); i++) begin
          total++;
          if (obs_terms[i] !== 16'(m_terms[i])) begin
            bad++;
            $display("FAIL %s term%0d got=%h want=%h", name, i + 1, obs_terms[i],
                     16'(m_terms[i]));
          end
        end
        total++;
        if (term_reg !== 16'(m_terms[m_terms.size() - 1])) begin
          bad++; $display("FAIL %s term_reg got=%h want=%h", name, term_reg,
                          16'(m_terms[m_terms.size() - 1]));
        end
      end
    end
  endtask

  task automatic test_reset();
    custom_reset = 1'b1;
    start = 1'b0;
    x_in  = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, overflow, term_init, term_load, result, term_d} !== 37'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, done, overflow, term_init, term_load, result, term_d});
    end
    custom_reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL reset_idle got=%b want=00", {busy, done});
    end
  endtask

  task automatic test_vectors();
    run_one(16'h0000, 16'h0800, "x_zero");
    run_one(16'h0800, 16'h15BD, "x_one");
    run_one(16'hF800, 16'h02F1, "x_minus_one");
    run_one(16'h7FFF, 16'h7FFF, "x_max");
    total++;
    if (obs_first_ovf !== 19) begin
      bad++; $display("FAIL x_max_ovf_cycle got=%0d want=19", obs_first_ovf);
    end
    run_one(16'h0100, 16'h0910, "x_eighth");
  endtask

  task automatic test_random();
    logic [15:0] x;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) x = 16'($urandom);
      else x = 16'($signed(32'($urandom_range(0, 8192)) - 32'd4096));
      run_one(x, -1, "random");
    end
  endtask

  task automatic test_abort();
    bit got_done = 0, got_busy = 0;
    @(negedge clk);
    x_in  = 16'h0800;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(negedge clk);
    custom_reset = 1'b1;
    @(negedge clk);
    custom_reset = 1'b0;
    total++;
    if ({busy, done, overflow, term_init, term_load, result, term_d} !== 37'd0) begin
      bad++;
      $display("FAIL abort_outputs got=%h want=0",
               {busy, done, overflow, term_init, term_load, result, term_d});
    end
    repeat (200) begin
      @(negedge clk);
      if (done) got_done = 1;
      if (busy) got_busy = 1;
    end
    total++;
    if ({got_done, got_busy} !== 2'b00) begin
      bad++; $display("FAIL abort_quiet got=%b want=00", {got_done, got_busy});
    end
  endtask

  task automatic test_start_ignored();
    int  dones = 0;
    bit  first = 0;
    @(negedge clk);
    x_in  = 16'h0800;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x_in = 16'h0100;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = (c == 30) ? 1'b1 : 1'b0;
      if (done) begin
        dones++;
        if (!first) begin first = 1; start = 1'b1; end
      end
    end
    start = 1'b0;
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL start_ignored_dones got=%0d want=1", dones);
    end
    total++;
    if ({busy, result} !== {1'b0, 16'h15BD}) begin
      bad++; $display("FAIL start_ignored_state got=%h want=%h", {busy, result},
                      {1'b0, 16'h15BD});
    end
  endtask

  task automatic test_back_to_back();
    run_one(16'h0400, -1, "b2b_0");
    run_one(16'hFC00, -1, "b2b_1");
    run_one(16'h1800, -1, "b2b_2");
    total++;
    if (both_hi !== 1'b0) begin
      bad++; $display("FAIL init_load_overlap got=%b want=0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taylor_exp_seq.md
Name: taylor_exp_seq

Overview:
- Sequencer that computes e^x in signed Q5.11 fixed point by Taylor series: term_n = term_(n-1) * x / n, sum += term_n.
- It is the driving end of the 16-bit term register. It pulses that register's init input (register goes to 1.0 = 16'h0800), writes each new term through its load/in pins, and reads the register output back.
- Sits between the top-level control (start/x_in) and the term register plus result consumer.

Parameters:
- WIDTH, 16, datapath width (signed Q5.11).
- FRAC, 11, fractional bits; 1.0 = 1 << FRAC.
- N_TERMS, 8, series terms including the constant 1.0 term; iterations n = 1 .. N_TERMS-1; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- custom_reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x_in  input  WIDTH  signed Q5.11 argument; latched when start is accepted.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; result valid from this cycle until the next accept.
- result  output  WIDTH  signed Q5.11 e^x, saturated.
- overflow  output  1  sticky saturation flag for the current run.
- term_init  output  1  to term register reset pin (sets 16'h0800).
- term_load  output  1  to term register load pin.
- term_d  output  WIDTH  to term register data input.
- term_q  input  WIDTH  term register output.

Behaviour:
- Reset: state IDLE. busy, done, term_init, term_load, overflow = 0. result, term_d, internal sum, x latch, n = 0.
- States: IDLE -> INIT -> MUL -> DIV -> WB -> (MUL | DONE) -> IDLE.
- IDLE
  - start=1 at edge k: latch x_in, clear overflow, go INIT.
  - start is ignored in every other state.
- INIT (1 cycle)
  - term_init=1, sum <= 16'h0800, n <= 1.
- MUL (1 cycle)
  - p = term_q * x as signed 32-bit, then arithmetic shift right by FRAC.
  - Saturate p to [-32768, 32767]; set overflow if clipped.
  - Register sign and magnitude |p| (17-bit safe).
- DIV (exactly 16 cycles)
  - Unsigned restoring divide |p| / n, truncating.
  - Reapply sign, so the division truncates toward zero.
- WB (1 cycle)
  - term_load=1, term_d = quotient.
  - sum <= saturating sum + quotient; set overflow on clip.
  - If n == N_TERMS-1 go DONE; else n++ and go MUL.
- DONE (1 cycle)
  - done=1, result <= sum (visible the same cycle via a registered copy at WB exit), busy=0.
  - Next state IDLE.
- Latency: done is high exactly 2 + 18*(N_TERMS-1) cycles after the accepting edge (128 for default).
- term_load and term_init are never high together. term_q is read only in MUL, one or more cycles after any load/init.
- custom_reset mid-run: abort immediately to reset values; no done pulse.
- start asserted in the same cycle as done: ignored; a new accept requires IDLE.

Optional Feature:
- Macro: TAYLOR_EARLY_EXIT_EN.
- Defined: in WB, a quotient of 0 transitions to DONE regardless of n. The term is still loaded and summed (adds 0). Latency becomes 2 + 18*n_exit.
- Undefined: always runs N_TERMS-1 iterations.
- Result value is identical either way.

Decomposition:
- Shared definitions include file (taylor_defs.vh): WIDTH, FRAC, ONE_Q = 16'h0800, SAT_MAX/SAT_MIN, FSM state encodings.
- Sub-module seq_divider: unsigned 16/16 restoring divider.
  - Interface: go, dividend, divisor, quotient, ready.
  - Fixed 16-cycle latency, same clk/custom_reset.

Test Plan:
- x_in=16'h0000 -> result 16'h0800, overflow 0, done exactly 128 cycles after accept.
- x_in=16'h0800 -> terms 2048, 1024, 341, 85, 17, 2, 0; result 16'h15BD; term register ends at 16'h0000.
- x_in=16'hF800 -> terms -2048, 1024, -341, 85, -17, 2, 0; result 16'h02F1; overflow 0.
- x_in=16'h7FFF -> result 16'h7FFF, overflow 1 from first WB onward.
- Assert custom_reset at cycle 40 of a run -> all outputs 0 next cycle, no done. Pulse start while busy -> ignored; exactly one done per accept.
- x_in=16'h0100 -> result 16'h0910. Done at cycle 56 with TAYLOR_EARLY_EXIT_EN, at cycle 128 without.
